// File: rtl/pwm_speed_decoder_pkg.sv
// Shared motor package: speed encoding used by the PWM generator, LED logic and this decoder,
// plus the duty thresholds and decoder FSM state type.
package pwm_speed_decoder_pkg;

    typedef enum logic [1:0] {
        SpeedStop    = 2'b00,
        SpeedSlow    = 2'b01,
        SpeedFast    = 2'b10,
        SpeedFastest = 2'b11
    } speed_state_t;

    typedef enum logic {
        StAcquire = 1'b0,
        StMeasure = 1'b1
    } dec_state_t;

    // Duty is compared as 16*H against N*P, so each level boundary sits at N/16.
    localparam int unsigned DutyShift    = 4;
    localparam int unsigned StopLimitNum = 2;
    localparam int unsigned SlowLimitNum = 6;
    localparam int unsigned FastLimitNum = 10;

endpackage

// File: rtl/pwm_speed_decoder_if.sv
// Measurement bus of the PWM speed decoder: the PWM line in, the published measurement out.
interface pwm_speed_decoder_if
    import pwm_speed_decoder_pkg::*;
#(
    parameter int unsigned CNT_WIDTH = 16
);

    logic                 pwm_in;
    logic [CNT_WIDTH-1:0] high_time;
    logic [CNT_WIDTH-1:0] period;
    speed_state_t         speed_level;
    logic                 meas_valid;
    logic                 stalled;

    modport master (
        input  pwm_in,
        output high_time,
        output period,
        output speed_level,
        output meas_valid,
        output stalled
    );

    modport slave (
        output pwm_in,
        input  high_time,
        input  period,
        input  speed_level,
        input  meas_valid,
        input  stalled
    );

endinterface

// File: rtl/pwm_speed_decoder_sync_edge_detect.sv
// Two-flop synchroniser for the asynchronous PWM line followed by a rising-edge detector.
module pwm_speed_decoder_sync_edge_detect (
    input  logic clk,
    input  logic reset_n,
    input  logic async_in,
    output logic synced,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= async_in;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign synced = sync2_q;
    assign rise   = sync2_q & ~prev_q;

endmodule

// File: rtl/pwm_speed_decoder.sv
// Measures high time and period of a motor PWM line, classifies the duty into a speed level
// and flags a line that has stopped toggling.
module pwm_speed_decoder
    import pwm_speed_decoder_pkg::*;
#(
    parameter int unsigned CNT_WIDTH      = 16,
    parameter int unsigned TIMEOUT_CYCLES = 16384
) (
    input logic                  clk,
    input logic                  reset_n,
    pwm_speed_decoder_if.master  bus
);

    localparam int unsigned ProdWidth = CNT_WIDTH + 5;
    localparam logic [CNT_WIDTH-1:0] TimeoutVal = CNT_WIDTH'(TIMEOUT_CYCLES);
    localparam logic [CNT_WIDTH-1:0] TimeoutPre = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] CntMax     = '1;
    localparam logic [CNT_WIDTH-1:0] CntOne     = CNT_WIDTH'(1);

    logic synced;
    logic rise;

    pwm_speed_decoder_sync_edge_detect u_sync_edge_detect (
        .clk      (clk),
        .reset_n  (reset_n),
        .async_in (bus.pwm_in),
        .synced   (synced),
        .rise     (rise)
    );

    dec_state_t           state_q;
    logic [CNT_WIDTH-1:0] period_cnt_q;
    logic [CNT_WIDTH-1:0] high_cnt_q;
    logic [CNT_WIDTH-1:0] high_time_q;
    logic [CNT_WIDTH-1:0] period_q;
    speed_state_t         speed_q;
    logic                 meas_valid_q;
    logic                 stalled_q;
    speed_state_t         speed_meas;
    logic                 timeout;

    function automatic speed_state_t classify(logic [CNT_WIDTH-1:0] h, logic [CNT_WIDTH-1:0] p);
        logic [ProdWidth-1:0] h16;
        logic [ProdWidth-1:0] p_stop;
        logic [ProdWidth-1:0] p_slow;
        logic [ProdWidth-1:0] p_fast;
        h16    = ProdWidth'(h) << DutyShift;
        p_stop = ProdWidth'(p) * ProdWidth'(StopLimitNum);
        p_slow = ProdWidth'(p) * ProdWidth'(SlowLimitNum);
        p_fast = ProdWidth'(p) * ProdWidth'(FastLimitNum);
        if (h16 < p_stop) begin
            return SpeedStop;
        end else if (h16 < p_slow) begin
            return SpeedSlow;
        end else if (h16 < p_fast) begin
            return SpeedFast;
        end
        return SpeedFastest;
    endfunction

    always_comb begin
        speed_meas = classify(high_cnt_q, period_cnt_q);
    end

    // Fires only on the step into saturation, so a held line yields a single timeout.
    assign timeout = !rise && (period_cnt_q == TimeoutPre);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            period_cnt_q <= '0;
            high_cnt_q   <= '0;
        end else begin
            if (rise) begin
                period_cnt_q <= CntOne;
            end else if (period_cnt_q != TimeoutVal) begin
                period_cnt_q <= period_cnt_q + CntOne;
            end
            if (rise) begin
                high_cnt_q <= CntOne;
            end else if (synced && (high_cnt_q != CntMax)) begin
                high_cnt_q <= high_cnt_q + CntOne;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= StAcquire;
            high_time_q  <= '0;
            period_q     <= '0;
            speed_q      <= SpeedStop;
            meas_valid_q <= 1'b0;
            stalled_q    <= 1'b0;
        end else begin
            meas_valid_q <= 1'b0;
            if (rise) begin
                state_q <= StMeasure;
                if (state_q == StMeasure) begin
                    high_time_q  <= high_cnt_q;
                    period_q     <= period_cnt_q;
                    speed_q      <= speed_meas;
                    meas_valid_q <= 1'b1;
                    stalled_q    <= 1'b0;
                end
            end else if (timeout) begin
                state_q      <= StAcquire;
                stalled_q    <= 1'b1;
                meas_valid_q <= 1'b1;
                speed_q      <= synced ? SpeedFastest : SpeedStop;
            end
        end
    end

    assign bus.high_time   = high_time_q;
    assign bus.period      = period_q;
    assign bus.speed_level = speed_q;
    assign bus.meas_valid  = meas_valid_q;
    assign bus.stalled     = stalled_q;

endmodule

// File: doc/pwm_speed_decoder.md
# pwm_speed_decoder

Measures a motor PWM waveform and reports high time, period and a quantised speed level. It sits on the receiving end of the motor PWM lines, for example as closed-loop feedback or as a board-level checker of the motor PWM generator. It classifies the measured duty into the shared four-level speed encoding (stop/slow/fast/fastest) and flags a stalled line.

## Interface
- CNT_WIDTH, 16: width of the high-time and period counters and outputs.
- TIMEOUT_CYCLES, 16384: cycles without a rising edge before the line is declared stalled; must be < 2^CNT_WIDTH.
- clk  input  1  system clock.
- reset_n  input  1  asynchronous, active-low reset.
- pwm_in  input  1  PWM line, asynchronous to clk.
- high_time  output  CNT_WIDTH  high cycles of the last complete period.
- period  output  CNT_WIDTH  rising-edge-to-rising-edge cycles of the last complete period.
- speed_level  output  2  speed_state_t: 00 STOP, 01 SLOW, 10 FAST, 11 FASTEST.
- meas_valid  output  1  one-cycle pulse when outputs update.
- stalled  output  1  level; set on timeout, cleared on next valid measurement.

## Operation
- pwm_in passes through a 2-flop synchroniser, then a registered previous-value edge detector. `rise` is true when synced=1 and prev=0.
- FSM states:
  - ACQUIRE (reset state): no period reference yet.
  - MEASURE: counting a period.
- period_cnt:
  - Loads 1 on `rise`; otherwise increments every cycle in both states.
  - Saturates at TIMEOUT_CYCLES.
- high_cnt:
  - Loads 1 on `rise`.
  - Otherwise increments while synced=1; saturates at all-ones.
- ACQUIRE + rise: load counters, go to MEASURE, no meas_valid.
- MEASURE + rise:
  - Publish high_time←high_cnt, period←period_cnt, speed_level←classify(high_cnt, period_cnt).
  - Pulse meas_valid, clear stalled, reload counters, stay in MEASURE.
- Classification uses CNT_WIDTH+5-bit unsigned products, no division:
  - STOP if 16·H < 2·P.
  - SLOW if 16·H < 6·P.
  - FAST if 16·H < 10·P.
  - Else FASTEST.
- Timeout, when period_cnt reaches TIMEOUT_CYCLES without `rise`, in either state:
  - Set stalled=1.
  - speed_level ← FASTEST if synced=1, else STOP.
  - Pulse meas_valid once.
  - high_time and period hold their last values.
  - Go to ACQUIRE; period_cnt stays saturated, so there is no repeated pulse.
- While stalled=1, the first `rise` acts as the ACQUIRE edge. stalled clears only at the following published measurement.

## Timing
- Reset values (async on reset_n=0):
  - ACQUIRE; all counters 0.
  - high_time=0, period=0, speed_level=STOP, meas_valid=0, stalled=0.
  - Synchroniser and prev flops 0.
- Latency: `rise` is true 2 cycles after the first clk edge that samples pwm_in=1. All outputs are registered and update on the clock edge ending the `rise` cycle; meas_valid is high for exactly that next cycle.
- For a clean wave with H cycles high and L cycles low: period=H+L, high_time=H.
- Minimum measurable pulse is 2 cycles high and 2 low; shorter pulses may be lost by the synchroniser.
- A rise coinciding with the timeout cycle is treated as rise; the timeout is ignored.
- Reset mid-period discards the partial measurement. The first valid measurement after release needs two rising edges.

## Structure
- The shared motor package holds:
  - speed_state_t (shared with the PWM generator and LED logic).
  - The threshold numerators 2/6/10 as localparams.
- One sub-module, sync_edge_detect: 2-flop synchroniser, prev flop, outputs synced level and `rise`; async active-low reset.
- The FSM, counters and classification live in pwm_speed_decoder.

## Test plan
- **Reset:** hold reset_n=0 while toggling pwm_in → all outputs 0, speed_level=STOP, no meas_valid. Release reset_n mid-cycle → no glitch.
- **Slow wave:** H=256, L=768 for 4 periods → no pulse on the first edge, then 3 meas_valid pulses 1024 cycles apart, each with high_time=256, period=1024, speed_level=SLOW.
- **Duty sweep at P=1024:**
  - H=512 → FAST.
  - H=768 → FASTEST.
  - H=16 → STOP.
  - H=128 → SLOW (boundary: 2048 is not < 2048).
  - H=127 → STOP.
- **Stall low:** after a valid measurement, hold pwm_in=0 → exactly one meas_valid with stalled=1 and speed_level=STOP, while high_time and period retain their old values. Resuming H=512, L=512 → stalled clears at the second rise, with speed_level=FAST.
- **Stall high:** hold pwm_in=1 for > TIMEOUT_CYCLES → stalled=1, speed_level=FASTEST, single pulse.
- **Mid-operation reset:** assert reset_n=0 halfway through the high phase → outputs clear immediately. After release, the first meas_valid arrives only after two rising edges, with correct values.
